uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised successor to the team's fixed 8-bit UART receiver. It adds configurable data width, selectable stop-bit count, majority-of-3 oversampled bit decisions, false-start rejection and explicit parity and framing error flags. The block sits between the async RX pin and the register-file/FIFO write side, in the single system clock domain. It reuses the existing PRESCALE/PAR_EN/PAR_TYP control scheme.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9), LSB first
PRESCALE_WIDTH, 6, width of PRESCALE input; supported runtime oversample ratio 4..2^PRESCALE_WIDTH-1
SYNC_STAGES, 2, RX_IN synchroniser flops (>=2)

Ports:
CLK  input  1  system clock (oversampling clock), rising edge
RST  input  1  asynchronous, active-low reset
PRESCALE  input  PRESCALE_WIDTH  CLK cycles per bit; must be >=4
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  0 = one stop bit, 1 = two stop bits
RX_IN  input  1  serial line, idle high, asynchronous
P_DATA  output  DATA_WIDTH  last good payload
DATA_VALID  output  1  one-cycle pulse: P_DATA updated with good frame
PAR_ERR  output  1  one-cycle pulse: parity mismatch
STP_ERR  output  1  one-cycle pulse: a stop bit sampled low
BUSY  output  1  high while FSM not IDLE

Behaviour:
- Reset (RST low, async): FSM=IDLE, all counters 0, synchroniser flops 1. P_DATA=0; DATA_VALID, PAR_ERR, STP_ERR, BUSY = 0.
- RX_IN passes through SYNC_STAGES flops; all logic below uses the synchronised rx_s. Fixed latency of SYNC_STAGES cycles.
- Configuration: PRESCALE, PAR_EN, PAR_TYP and STOP2 are latched on the IDLE->START transition. Mid-frame changes are ignored.
- Counters: edge_cnt runs 0..PS-1 (PS = latched prescale) and wraps to 0 at each bit boundary. bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling: samples are taken at edge_cnt = PS/2-1, PS/2 and PS/2+1 (integer division). Bit value = majority of 3, decided at PS/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s is 0, go to START with edge_cnt=0.
  - START: at the decision point, if the majority is 1 this is a false start: return to IDLE with no flags. Otherwise continue to DATA at the wrap.
  - DATA: shift the decided bit into bit position bit_cnt (LSB first). After bit DATA_WIDTH-1 wraps, go to PARITY if PAR_EN, else STOP.
  - PARITY: expected = XOR(data) XOR PAR_TYP. A mismatch sets the internal par_bad flag.
  - STOP: if any stop bit decides 0, set stp_bad. With STOP2=1, two stop bit periods are checked.
- Frame end: at the decision point of the last stop bit, the FSM goes straight to IDLE. It does not wait for the bit end, so back-to-back frames resynchronise on the next start edge. Flags are registered and appear on the next cycle:
  - Good frame (no par_bad, no stp_bad): P_DATA <= shift register, DATA_VALID=1.
  - Bad frame: PAR_ERR=par_bad and STP_ERR=stp_bad (both may be 1 in the same cycle). DATA_VALID=0 and P_DATA holds its previous value.
- All pulses last exactly one CLK cycle. P_DATA is stable between good frames.
- Line held low (break): a stop-bit failure gives STP_ERR. The FSM then returns to IDLE, immediately sees rx_s=0 and re-enters START. No lockup; a repeated STP_ERR per frame time is acceptable.
- If PRESCALE < 4 is latched, behaviour is undefined. The verification bench must not drive it.
- BUSY = (state != IDLE).

Decomposition:
- Shared package uart_pkg: FSM state enum; constant MIN_PRESCALE=4; parity helper function (reduction XOR plus type bit). The future uart_tx_param uses the same package.
- One sub-module, uart_rx_sampler: edge counter, three-sample capture, majority vote and the sample_done strobe. The FSM, shift register and flag logic stay in uart_rx_param.

Test Plan:
1. PRESCALE=8, PAR_EN=1, PAR_TYP=0, STOP2=0; send 0xA5 with parity 0 -> one DATA_VALID pulse, P_DATA=0xA5, no error flags, BUSY low afterwards.
2. Same config; send 0x3C with parity bit 1 (wrong) -> PAR_ERR pulse, DATA_VALID=0, P_DATA keeps 0xA5.
3. PRESCALE=16, PAR_EN=0, STOP2=1; send 0x81 with the second stop bit 0 -> STP_ERR pulse only, P_DATA unchanged. Then a clean 0x81 -> DATA_VALID, P_DATA=0x81.
4. PRESCALE=8; a 2-cycle low glitch on the idle line -> false start, FSM back to IDLE, no pulses, BUSY high for at most 5 cycles.
5. PRESCALE=8; 0x55, 0xAA, 0xFF sent back-to-back with no idle gap, plus a single-cycle inverted glitch on one middle sample of each bit -> three DATA_VALID pulses carrying 0x55, 0xAA, 0xFF (majority vote masks the glitch).
6. Assert RST low mid-DATA of frame 0x12 -> all outputs 0 immediately. After release, next frame 0x34 -> DATA_VALID, P_DATA=0x34.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART receiver and transmitter:
//   - uart_state_e : receive/transmit frame FSM states
//   - MIN_PRESCALE : smallest oversample ratio the bit timing supports
//   - parity_bit() : expected parity bit for a payload (even/odd selectable)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Three samples around mid-bit need at least 4 clocks per bit.
  localparam int MIN_PRESCALE = 4;

  // Widest payload the parity helper accepts; narrower payloads are
  // zero-extended, which leaves the XOR unchanged.
  localparam int PAR_MAX_W = 16;

  // Expected parity bit: 0 = even (total ones even), 1 = odd.
  function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] data,
                                      input logic                 par_typ);
    return (^data) ^ par_typ;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Bit-period timing for the UART receiver: edge counter, three-sample capture
// around mid-bit, majority vote and the decision/wrap strobes.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_idle         : receiver FSM is in IDLE
//   i_rx           : synchronised serial line
//   i_ps           : latched prescale (clocks per bit)
//   o_done         : decision point (edge = PS/2+1), o_bit is valid
//   o_bit          : majority of the three samples
//   o_wrap         : last clock of the bit period (edge = PS-1)
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_idle,
  input  logic                      i_rx,
  input  logic [PRESCALE_WIDTH-1:0] i_ps,
  output logic                      o_done,
  output logic                      o_bit,
  output logic                      o_wrap
);

  logic [PRESCALE_WIDTH-1:0] r_edge;
  logic                      r_s0;
  logic                      r_s1;

  logic [PRESCALE_WIDTH-1:0] w_half;
  logic [PRESCALE_WIDTH-1:0] w_lo;
  logic [PRESCALE_WIDTH-1:0] w_hi;
  logic                      w_last;

  assign w_half = i_ps >> 1;
  assign w_lo   = w_half - PRESCALE_WIDTH'(1);
  assign w_hi   = w_half + PRESCALE_WIDTH'(1);
  assign w_last = (r_edge == (i_ps - PRESCALE_WIDTH'(1)));

  // Edge counter and early/middle sample capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge <= '0;
      r_s0   <= 1'b1;
      r_s1   <= 1'b1;
    end else if (i_idle) begin
      // The clock that first sees the line low is edge 0 of the start bit,
      // so the first START clock is already edge 1.
      r_edge <= i_rx ? '0 : PRESCALE_WIDTH'(1);
    end else begin
      if (r_edge == w_lo) begin
        r_s0 <= i_rx;
      end
      if (r_edge == w_half) begin
        r_s1 <= i_rx;
      end
      r_edge <= w_last ? '0 : (r_edge + PRESCALE_WIDTH'(1));
    end
  end

  // Third sample is the live line at the decision point.
  assign o_bit  = (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
  assign o_done = !i_idle && (r_edge == w_hi);
  assign o_wrap = !i_idle && w_last;

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver: majority-voted bit decisions, false-start
// rejection, optional parity, one or two stop bits, parity/framing flags.
// Ports:
//   CLK, RST        : oversampling clock, async active-low reset
//   PRESCALE        : clocks per bit (>= 4), latched at frame start
//   PAR_EN, PAR_TYP : parity present / 0 even, 1 odd (latched)
//   STOP2           : two stop bits when 1 (latched)
//   RX_IN           : asynchronous serial line, idle high
//   P_DATA          : last good payload
//   DATA_VALID      : 1-cycle pulse, P_DATA updated
//   PAR_ERR/STP_ERR : 1-cycle error pulses for a bad frame
//   BUSY            : FSM not IDLE
// -----------------------------------------------------------------------------
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic                      RX_IN,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR,
  output logic                      BUSY
);

  localparam int BCW = $clog2(DATA_WIDTH);

  logic [SYNC_STAGES-1:0]    r_sync;
  uart_state_e               r_state;
  logic [PRESCALE_WIDTH-1:0] r_ps;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic                      r_stop2;
  logic [BCW-1:0]            r_bit_cnt;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic                      r_stop_idx;
  logic                      r_par_bad;
  logic                      r_stp_bad;
  logic [DATA_WIDTH-1:0]     r_p_data;
  logic                      r_valid;
  logic                      r_par_err;
  logic                      r_stp_err;

  logic w_rx;
  logic w_done;
  logic w_bit;
  logic w_wrap;
  logic w_idle;
  logic w_stp_fin;
  logic w_last_stop;

  // RX_IN synchroniser; resets to the idle (high) line level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], RX_IN};
    end
  end

  assign w_rx   = r_sync[SYNC_STAGES-1];
  assign w_idle = (r_state == ST_IDLE);

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .i_clk  (CLK),
    .i_rst_n(RST),
    .i_idle (w_idle),
    .i_rx   (w_rx),
    .i_ps   (r_ps),
    .o_done (w_done),
    .o_bit  (w_bit),
    .o_wrap (w_wrap)
  );

  // Framing error including the stop bit being decided right now.
  assign w_stp_fin   = r_stp_bad | ~w_bit;
  assign w_last_stop = !r_stop2 || r_stop_idx;

  // Frame FSM, shift register, error tracking and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_ps       <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_stop2    <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_stop_idx <= 1'b0;
      r_par_bad  <= 1'b0;
      r_stp_bad  <= 1'b0;
      r_p_data   <= '0;
      r_valid    <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx) begin
            r_state    <= ST_START;
            r_ps       <= PRESCALE;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_stop2    <= STOP2;
            r_bit_cnt  <= '0;
            r_stop_idx <= 1'b0;
            r_par_bad  <= 1'b0;
            r_stp_bad  <= 1'b0;
          end
        end
        ST_START: begin
          // A start bit that votes high was noise: drop it silently.
          if (w_done && w_bit) begin
            r_state <= ST_IDLE;
          end else if (w_wrap) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_done) begin
            r_shift[r_bit_cnt] <= w_bit;
          end
          if (w_wrap) begin
            if (r_bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (w_done) begin
            r_par_bad <= (w_bit != parity_bit(PAR_MAX_W'(r_shift), r_par_typ));
          end
          if (w_wrap) begin
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_done) begin
            if (w_last_stop) begin
              // Leave at the decision point so the next start edge is caught.
              r_state <= ST_IDLE;
              if (!r_par_bad && !w_stp_fin) begin
                r_p_data <= r_shift;
                r_valid  <= 1'b1;
              end else begin
                r_par_err <= r_par_bad;
                r_stp_err <= w_stp_fin;
              end
            end else begin
              r_stp_bad <= w_stp_fin;
            end
          end else if (w_wrap) begin
            r_stop_idx <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign P_DATA     = r_p_data;
  assign DATA_VALID = r_valid;
  assign PAR_ERR    = r_par_err;
  assign STP_ERR    = r_stp_err;
  assign BUSY       = !w_idle;

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Directed self-checking bench for uart_rx_param (DATA_WIDTH=8).
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic       RX_IN = 1'b1;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       BUSY;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Pulse/BUSY monitors: monotonic counters, read as deltas by the stimulus.
  int         n_valid = 0;
  int         n_par = 0;
  int         n_stp = 0;
  int         n_busy = 0;
  logic [7:0] vq[$];

  uart_rx_param #(
    .DATA_WIDTH(8),
    .PRESCALE_WIDTH(6),
    .SYNC_STAGES(2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PRESCALE  (PRESCALE),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .STOP2     (STOP2),
    .RX_IN     (RX_IN),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RST) begin
      if (DATA_VALID) begin
        n_valid++;
        vq.push_back(P_DATA);
      end
      if (PAR_ERR) n_par++;
      if (STP_ERR) n_stp++;
      if (BUSY) n_busy++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK) RX_IN = 1'b1;
    end
  endtask

  // Start, nd data bits LSB first, optional parity, one or two stop bits.
  // glitch inverts the line for the single middle clock of every bit.
  task automatic send_frame(input int ps, input logic [8:0] d, input int nd,
                            input bit pe, input bit pb, input bit st2,
                            input bit s1, input bit s2, input bit glitch,
                            input int gap);
    logic [15:0] f;
    int          n;
    logic        v;
    f    = '0;
    f[0] = 1'b0;
    n    = 1;
    for (int i = 0; i < nd; i++) begin
      f[n] = d[i];
      n++;
    end
    if (pe) begin
      f[n] = pb;
      n++;
    end
    f[n] = s1;
    n++;
    if (st2) begin
      f[n] = s2;
      n++;
    end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < ps; c++) begin
        v = f[b];
        if (glitch && (c == ps / 2)) v = ~v;
        @(negedge CLK) RX_IN = v;
      end
    end
    idle(gap);
  endtask

  int v0, p0, s0, b0, q0;

  task automatic snap();
    v0 = n_valid;
    p0 = n_par;
    s0 = n_stp;
    b0 = n_busy;
    q0 = vq.size();
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge CLK);
    chk("rst_pdata", 32'(P_DATA), 32'h0);
    chk("rst_valid", 32'(DATA_VALID), 32'h0);
    chk("rst_parerr", 32'(PAR_ERR), 32'h0);
    chk("rst_stperr", 32'(STP_ERR), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    RST = 1'b1;
    idle(5);

    // 1: 0xA5, even parity bit 0 is correct.
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
    snap();
    send_frame(8, 9'h0A5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24);
    chk("t1_valid", 32'(n_valid - v0), 32'd1);
    chk("t1_pdata", 32'(P_DATA), 32'hA5);
    chk("t1_parerr", 32'(n_par - p0), 32'd0);
    chk("t1_stperr", 32'(n_stp - s0), 32'd0);
    chk("t1_busy", 32'(BUSY), 32'h0);

    // 2: 0x3C has four ones, parity bit 1 is wrong under even parity.
    snap();
    send_frame(8, 9'h03C, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24);
    chk("t2_parerr", 32'(n_par - p0), 32'd1);
    chk("t2_valid", 32'(n_valid - v0), 32'd0);
    chk("t2_stperr", 32'(n_stp - s0), 32'd0);
    chk("t2_pdata", 32'(P_DATA), 32'hA5);

    // 3: two stop bits, second one low -> framing error only; then clean.
    PRESCALE = 6'd16; PAR_EN = 1'b0; STOP2 = 1'b1;
    snap();
    send_frame(16, 9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 48);
    chk("t3_stperr", 32'(n_stp - s0), 32'd1);
    chk("t3_valid", 32'(n_valid - v0), 32'd0);
    chk("t3_parerr", 32'(n_par - p0), 32'd0);
    chk("t3_pdata_hold", 32'(P_DATA), 32'hA5);
    snap();
    send_frame(16, 9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 48);
    chk("t3_clean_valid", 32'(n_valid - v0), 32'd1);
    chk("t3_clean_pdata", 32'(P_DATA), 32'h81);

    // 4: 2-cycle low glitch on idle line -> false start.
    PRESCALE = 6'd8; STOP2 = 1'b0;
    snap();
    @(negedge CLK) RX_IN = 1'b0;
    @(negedge CLK) RX_IN = 1'b0;
    idle(40);
    chk("t4_busy_bound", 32'((n_busy - b0) >= 1 && (n_busy - b0) <= 5), 32'd1);
    chk("t4_valid", 32'(n_valid - v0), 32'd0);
    chk("t4_parerr", 32'(n_par - p0), 32'd0);
    chk("t4_stperr", 32'(n_stp - s0), 32'd0);
    chk("t4_busy_end", 32'(BUSY), 32'h0);

    // 5: back-to-back frames with a mid-sample glitch on every bit.
    snap();
    send_frame(8, 9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    send_frame(8, 9'h0AA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    send_frame(8, 9'h0FF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24);
    chk("t5_nvalid", 32'(n_valid - v0), 32'd3);
    if (vq.size() >= q0 + 3) begin
      chk("t5_d0", 32'(vq[q0]), 32'h55);
      chk("t5_d1", 32'(vq[q0 + 1]), 32'hAA);
      chk("t5_d2", 32'(vq[q0 + 2]), 32'hFF);
    end else begin
      chk("t5_qsize", 32'(vq.size() - q0), 32'd3);
    end
    chk("t5_errs", 32'((n_par - p0) + (n_stp - s0)), 32'd0);

    // 6: async reset in the middle of DATA of 0x12, then a clean 0x34.
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge CLK) RX_IN = (b == 0) ? 1'b0 : ((8'h12 >> (b - 1)) & 8'h01) != 8'h00;
      end
    end
    chk("t6_busy_mid", 32'(BUSY), 32'h1);
    #2 RST = 1'b0;
    RX_IN = 1'b1;
    #1;
    chk("t6_rst_pdata", 32'(P_DATA), 32'h0);
    chk("t6_rst_valid", 32'(DATA_VALID), 32'h0);
    chk("t6_rst_parerr", 32'(PAR_ERR), 32'h0);
    chk("t6_rst_stperr", 32'(STP_ERR), 32'h0);
    chk("t6_rst_busy", 32'(BUSY), 32'h0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(5);
    snap();
    send_frame(8, 9'h034, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24);
    chk("t6_valid", 32'(n_valid - v0), 32'd1);
    chk("t6_pdata", 32'(P_DATA), 32'h34);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
